// File: rtl/vscale_retire_trace_buf_if.sv
// Retire-trace bus: retire-event capture side plus the drained word stream.
// Ports: trace_en/retire_*/cycle_lo/out_ready driven by master (pipeline + consumer);
//        out_valid/out_data/out_last/level/overflow driven by slave (the trace buffer).
interface vscale_retire_trace_buf_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  trace_en;
  logic                  retire_valid;
  logic                  retire_fp;
  logic                  retire_wr;
  logic [4:0]            retire_rd;
  logic [31:0]           retire_pc;
  logic [31:0]           retire_inst;
  logic [31:0]           retire_data;
  logic                  retire_exc;
  logic [3:0]            retire_ecode;
  logic [7:0]            cycle_lo;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_data;
  logic                  out_last;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;

  modport master (
    output trace_en, retire_valid, retire_fp, retire_wr, retire_rd, retire_pc,
           retire_inst, retire_data, retire_exc, retire_ecode, cycle_lo, out_ready,
    input  out_valid, out_data, out_last, level, overflow
  );

  modport slave (
    input  trace_en, retire_valid, retire_fp, retire_wr, retire_rd, retire_pc,
           retire_inst, retire_data, retire_exc, retire_ecode, cycle_lo, out_ready,
    output out_valid, out_data, out_last, level, overflow
  );
endinterface

// File: rtl/vscale_retire_trace_buf.sv
// Purpose: captures one 4-word record per retired instruction into a record FIFO and
//          drains it as 32-bit words (header, pc, inst, data) on a valid/ready stream.
// Latency: record pushed in cycle N shows its header in cycle N+1 when the FIFO was empty.
// Backpressure: out_ready low holds the current word; a full FIFO drops new records,
//               counting them (saturating at 15) into the next header and setting sticky overflow.
// Ports: i_clk, i_reset (async, active-high); io_trace = slave side of the trace bus.
module vscale_retire_trace_buf #(
  parameter int DEPTH_LOG2 = 3   // must match the DEPTH_LOG2 of the connected interface
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  vscale_retire_trace_buf_if.slave    io_trace
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef struct packed {
    logic [7:0] tag;
    logic       fp;
    logic       wr;
    logic       exc;
    logic [4:0] rd;
    logic [3:0] ecode;
    logic [3:0] drop;
    logic [7:0] cyc;
  } hdr_t;

  logic [31:0]            r_mem [DEPTH][4];
  logic [DEPTH_LOG2-1:0]  r_wr_ptr;
  logic [DEPTH_LOG2-1:0]  r_rd_ptr;
  logic [DEPTH_LOG2:0]    r_level;
  logic [1:0]             r_idx;
  logic [3:0]             r_drop_cnt;
  logic                   r_overflow;

  logic  w_req;
  logic  w_full;
  logic  w_push;
  logic  w_drop;
  logic  w_out_vld;
  logic  w_hs;
  logic  w_pop;
  hdr_t  w_hdr;

  // Full is judged on the registered level only: a final-word pop in the same
  // cycle does not make room for an incoming record.
  assign w_req     = io_trace.retire_valid & io_trace.trace_en;
  assign w_full    = (r_level == LP_FULL);
  assign w_push    = w_req & ~w_full;
  assign w_drop    = w_req & w_full;
  assign w_out_vld = (r_level != '0);
  assign w_hs      = w_out_vld & io_trace.out_ready;
  assign w_pop     = w_hs & (r_idx == 2'd3);

  always_comb begin
    w_hdr       = '0;
    w_hdr.tag   = 8'hA5;
    w_hdr.fp    = io_trace.retire_fp;
    w_hdr.wr    = io_trace.retire_wr;
    w_hdr.exc   = io_trace.retire_exc;
    w_hdr.rd    = io_trace.retire_rd;
    w_hdr.ecode = io_trace.retire_ecode;
    w_hdr.drop  = r_drop_cnt;
    w_hdr.cyc   = io_trace.cycle_lo;
  end

  // Record storage carries no reset; stale contents are never visible because
  // the output is gated by level.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr][0] <= w_hdr;
      r_mem[r_wr_ptr][1] <= io_trace.retire_pc;
      r_mem[r_wr_ptr][2] <= io_trace.retire_inst;
      r_mem[r_wr_ptr][3] <= io_trace.retire_wr ? io_trace.retire_data : 32'h0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_idx      <= 2'd0;
      r_drop_cnt <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_hs) begin
        r_idx <= r_idx + 2'd1;   // wraps 3 -> 0 on the final word
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // Drop count is handed to the header of the next captured record.
      if (w_push) begin
        r_drop_cnt <= 4'd0;
      end else if (w_drop) begin
        if (r_drop_cnt != 4'hF) begin
          r_drop_cnt <= r_drop_cnt + 4'd1;
        end
        r_overflow <= 1'b1;
      end
    end
  end

  assign io_trace.out_valid = w_out_vld;
  assign io_trace.out_data  = w_out_vld ? r_mem[r_rd_ptr][r_idx] : 32'h0;
  assign io_trace.out_last  = w_out_vld & (r_idx == 2'd3);
  assign io_trace.level     = r_level;
  assign io_trace.overflow  = r_overflow;

endmodule
